// File: rtl/avoid_decision.sv
// Obstacle-avoidance decision stage: samples left/right echo times, confirms near obstacles with
// hysteresis, and sequences timed drive manoeuvres. Define AVOID_BACKOFF_EN to enable the reverse state.
module avoid_decision #(
    parameter int unsigned SAMPLE_CYCLES = 3000000,
    parameter int unsigned NEAR_TH       = 58000,
    parameter int unsigned CLEAR_TH      = 87000,
    parameter int unsigned CONFIRM       = 3,
    parameter int unsigned BACK_CYCLES   = 15000000,
    parameter int unsigned TURN_CYCLES   = 25000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [19:0] left_time,
    input  logic [19:0] right_time,
    output logic [2:0]  cmd,
    output logic        obstacle_l,
    output logic        obstacle_r,
    output logic        busy
);

    localparam int unsigned CNT_W   = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam int unsigned TMR_MAX = (BACK_CYCLES > TURN_CYCLES) ? BACK_CYCLES : TURN_CYCLES;
    localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TURN_LAST   = TMR_W'(TURN_CYCLES - 1);
`ifdef AVOID_BACKOFF_EN
    localparam logic [TMR_W-1:0] BACK_LAST   = TMR_W'(BACK_CYCLES - 1);
`endif
    localparam logic [19:0]      NEAR_T      = 20'(NEAR_TH);
    localparam logic [19:0]      CLEAR_T     = 20'(CLEAR_TH);
    localparam logic [3:0]       CONFIRM_C   = 4'(CONFIRM);

    localparam logic [2:0] CMD_STOP  = 3'b000;
    localparam logic [2:0] CMD_FWD   = 3'b001;
`ifdef AVOID_BACKOFF_EN
    localparam logic [2:0] CMD_BACK  = 3'b010;
`endif
    localparam logic [2:0] CMD_LEFT  = 3'b011;
    localparam logic [2:0] CMD_RIGHT = 3'b100;

    typedef enum logic [2:0] {
        ST_START   = 3'd0,
        ST_FWD     = 3'd1,
`ifdef AVOID_BACKOFF_EN
        ST_BACKOFF = 3'd2,
`endif
        ST_TURN_L  = 3'd3,
        ST_TURN_R  = 3'd4
    } state_t;

    typedef struct packed {
        logic [3:0] cnt;
        logic       flag;
    } side_t;

    logic [CNT_W-1:0] sample_cnt;
    logic             tick;
    side_t            side_l, side_r;
    side_t            side_l_nxt, side_r_nxt;
    state_t           state, state_nxt, turn_pick;
    logic [TMR_W-1:0] timer;

    // Zero means "no echo measured" and leaves the side untouched.
    function automatic side_t classify(input logic [19:0] t, input side_t cur);
        side_t nxt;
        nxt = cur;
        if (t != '0) begin
            if (t < NEAR_T) begin
                if (cur.cnt != CONFIRM_C)
                    nxt.cnt = cur.cnt + 4'd1;
                if (nxt.cnt == CONFIRM_C)
                    nxt.flag = 1'b1;
            end else if (t >= CLEAR_T) begin
                nxt.cnt  = '0;
                nxt.flag = 1'b0;
            end else begin
                nxt.cnt = '0;
            end
        end
        return nxt;
    endfunction

    function automatic logic [2:0] cmd_of(input state_t s);
        logic [2:0] c;
        c = CMD_STOP;
        case (s)
            ST_FWD:     c = CMD_FWD;
`ifdef AVOID_BACKOFF_EN
            ST_BACKOFF: c = CMD_BACK;
`endif
            ST_TURN_L:  c = CMD_LEFT;
            ST_TURN_R:  c = CMD_RIGHT;
            default:    c = CMD_STOP;
        endcase
        return c;
    endfunction

    function automatic logic is_manoeuvre(input state_t s);
        return (s == ST_TURN_L) || (s == ST_TURN_R)
`ifdef AVOID_BACKOFF_EN
            || (s == ST_BACKOFF)
`endif
            ;
    endfunction

    assign tick       = (sample_cnt == SAMPLE_LAST);
    assign side_l_nxt = classify(left_time, side_l);
    assign side_r_nxt = classify(right_time, side_r);
    assign obstacle_l = side_l.flag;
    assign obstacle_r = side_r.flag;
    // Ties, including both sides zero, turn right.
    assign turn_pick  = (left_time > right_time) ? ST_TURN_L : ST_TURN_R;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= '0;
            side_l     <= '0;
            side_r     <= '0;
        end else begin
            sample_cnt <= tick ? '0 : sample_cnt + CNT_W'(1);
            if (tick) begin
                side_l <= side_l_nxt;
                side_r <= side_r_nxt;
            end
        end
    end

    // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            ST_START: if (tick) state_nxt = ST_FWD;
            ST_FWD: begin
                if (side_l.flag && side_r.flag)
`ifdef AVOID_BACKOFF_EN
                    state_nxt = ST_BACKOFF;
`else
                    state_nxt = turn_pick;
`endif
                else if (side_l.flag)
                    state_nxt = ST_TURN_R;
                else if (side_r.flag)
                    state_nxt = ST_TURN_L;
            end
`ifdef AVOID_BACKOFF_EN
            ST_BACKOFF: if (timer == BACK_LAST) state_nxt = turn_pick;
`endif
            ST_TURN_L, ST_TURN_R: if (timer == TURN_LAST) state_nxt = ST_FWD;
            default: state_nxt = ST_START;
        endcase
    end

    // Timer restarts on every state entry and only advances while a manoeuvre is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_START;
            timer <= '0;
            cmd   <= CMD_STOP;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            timer <= ((state_nxt == state) && is_manoeuvre(state)) ? timer + TMR_W'(1) : '0;
            cmd   <= cmd_of(state_nxt);
            busy  <= is_manoeuvre(state_nxt);
        end
    end

endmodule

// File: tb/tb_avoid_decision.sv
// Scoreboard bench for avoid_decision: each expected output change (value and clock edge) is queued
// by the stimulus; a monitor pops and compares whenever the output vector changes.
module tb_avoid_decision;

    localparam logic [2:0] C_STOP  = 3'b000;
    localparam logic [2:0] C_FWD   = 3'b001;
`ifdef AVOID_BACKOFF_EN
    localparam logic [2:0] C_BACK  = 3'b010;
`endif
    localparam logic [2:0] C_LEFT  = 3'b011;
    localparam logic [2:0] C_RIGHT = 3'b100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [19:0] left_time, right_time;
    logic [2:0]  cmd;
    logic        obstacle_l, obstacle_r, busy;

    avoid_decision #(
        .SAMPLE_CYCLES(100),
        .NEAR_TH(1000),
        .CLEAR_TH(1500),
        .CONFIRM(3),
        .BACK_CYCLES(300),
        .TURN_CYCLES(500)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .left_time(left_time),
        .right_time(right_time),
        .cmd(cmd),
        .obstacle_l(obstacle_l),
        .obstacle_r(obstacle_r),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Number of rising edges since reset was last released.
    int edge_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    typedef struct {
        int         at_edge;
        logic [5:0] outv;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [5:0] ov(input logic [2:0] c, input logic l, input logic r, input logic b);
        return {c, l, r, b};
    endfunction

    task automatic expect_ev(input string name, input int e, input logic [5:0] v);
        exp_t x;
        x.at_edge = e;
        x.outv    = v;
        x.name    = name;
        exp_q.push_back(x);
    endtask

    task automatic check(input string name, input logic [5:0] act_v, input int act_e,
                         input logic [5:0] exp_v, input int exp_e);
        checks++;
        if (act_v !== exp_v || act_e != exp_e) begin
            errors++;
            $display("FAIL %s: {cmd,obs_l,obs_r,busy}=%b at edge %0d, expected %b at edge %0d",
                     name, act_v, act_e, exp_v, exp_e);
        end
    endtask

    logic [5:0] prev_v;
    bit         first = 1'b1;

    task automatic monitor_sample();
        logic [5:0] cur_v;
        exp_t       e;
        cur_v = {cmd, obstacle_l, obstacle_r, busy};
        if (first || cur_v !== prev_v) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_change: outputs became %b at edge %0d, no change expected",
                         cur_v, edge_cnt);
            end else begin
                e = exp_q.pop_front();
                check(e.name, cur_v, edge_cnt, e.outv, e.at_edge);
            end
            prev_v = cur_v;
            first  = 1'b0;
        end
    endtask

    initial begin
        #3;
        monitor_sample();
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            monitor_sample();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d expectations pending", exp_q.size());
        $fatal(1);
    end

    task automatic wait_edge(input int n);
        while (edge_cnt < n) @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b1;
        left_time  = 20'd5000;
        right_time = 20'd5000;

        // Reset state, then START -> FWD on the first tick (counter 99, edge 100).
        expect_ev("reset_state", 0, ov(C_STOP, 0, 0, 0));
        expect_ev("start_to_fwd", 100, ov(C_FWD, 0, 0, 0));
        #2 rst_n = 1'b0;
        #30 rst_n = 1'b1;

        // Right near on ticks 200/300/400: flag after the third, then a 500-cycle left turn.
        expect_ev("right_flag_set", 400, ov(C_FWD, 0, 1, 0));
        expect_ev("turn_left_start", 401, ov(C_LEFT, 0, 1, 1));
        expect_ev("right_flag_clear", 500, ov(C_LEFT, 0, 0, 1));
        expect_ev("turn_left_end", 901, ov(C_FWD, 0, 0, 0));
        wait_edge(150);  right_time = 20'd800;
        wait_edge(450);  right_time = 20'd1600;

        // Both sides near with a tie.
        expect_ev("both_flags_set", 1200, ov(C_FWD, 1, 1, 0));
`ifdef AVOID_BACKOFF_EN
        expect_ev("backoff_start", 1201, ov(C_BACK, 1, 1, 1));
        expect_ev("flags_clear_in_backoff", 1300, ov(C_BACK, 0, 0, 1));
        expect_ev("tie_turns_right", 1501, ov(C_RIGHT, 0, 0, 1));
        expect_ev("turn_right_end", 2001, ov(C_FWD, 0, 0, 0));
`else
        expect_ev("tie_turns_right", 1201, ov(C_RIGHT, 1, 1, 1));
        expect_ev("flags_clear_in_turn", 1300, ov(C_RIGHT, 0, 0, 1));
        expect_ev("turn_right_end", 1701, ov(C_FWD, 0, 0, 0));
`endif
        wait_edge(950);  left_time = 20'd800; right_time = 20'd800;
        wait_edge(1250); left_time = 20'd1600; right_time = 20'd1600;

        // Hysteresis band holds the flag; a clear sample drops it on that tick.
        expect_ev("hyst_flag_set", 2300, ov(C_FWD, 0, 1, 0));
        expect_ev("hyst_turn_start", 2301, ov(C_LEFT, 0, 1, 1));
        expect_ev("clear_after_band", 2600, ov(C_LEFT, 0, 0, 1));
        expect_ev("hyst_turn_end", 2801, ov(C_FWD, 0, 0, 0));
        wait_edge(2050); right_time = 20'd800;
        wait_edge(2350); right_time = 20'd1200;
        wait_edge(2550); right_time = 20'd1600;

        // Zero samples between near samples are ignored.
        expect_ev("zero_ignored_flag_set", 3300, ov(C_FWD, 0, 1, 0));
        expect_ev("zero_turn_start", 3301, ov(C_LEFT, 0, 1, 1));
        expect_ev("zero_flag_clear", 3400, ov(C_LEFT, 0, 0, 1));
        expect_ev("zero_turn_end", 3801, ov(C_FWD, 0, 0, 0));
        wait_edge(2850); right_time = 20'd800;
        wait_edge(2950); right_time = 20'd0;
        wait_edge(3050); right_time = 20'd800;
        wait_edge(3150); right_time = 20'd0;
        wait_edge(3250); right_time = 20'd800;
        wait_edge(3350); right_time = 20'd1600;

        // Left: near, near, band, near, near, near -> flag only on the last.
        expect_ev("band_restart_flag_l", 4400, ov(C_FWD, 1, 0, 0));
        expect_ev("left_only_turns_right", 4401, ov(C_RIGHT, 1, 0, 1));
        expect_ev("left_flag_clear", 4500, ov(C_RIGHT, 0, 0, 1));
        expect_ev("left_turn_end", 4901, ov(C_FWD, 0, 0, 0));
        wait_edge(3850); left_time = 20'd800;
        wait_edge(4050); left_time = 20'd1200;
        wait_edge(4150); left_time = 20'd800;
        wait_edge(4450); left_time = 20'd1600;

        // Async reset in the middle of a left turn; counters must restart from zero.
        expect_ev("pre_reset_flag", 5200, ov(C_FWD, 0, 1, 0));
        expect_ev("pre_reset_turn", 5201, ov(C_LEFT, 0, 1, 1));
        expect_ev("async_reset", 0, ov(C_STOP, 0, 0, 0));
        expect_ev("restart_fwd", 100, ov(C_FWD, 0, 1, 0));
        wait_edge(4950); right_time = 20'd800;
        wait_edge(5300);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;

        // After restart the right side is still near: ticks 100/200/300 confirm afresh.
        exp_q.delete(exp_q.size() - 1);
        expect_ev("restart_fwd", 100, ov(C_FWD, 0, 0, 0));
        expect_ev("restart_flag", 300, ov(C_FWD, 0, 1, 0));
        expect_ev("restart_turn", 301, ov(C_LEFT, 0, 1, 1));
        wait_edge(350);

        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: expected %b at edge %0d never observed", e.name, e.outv, e.at_edge);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/avoid_decision.md
Name: avoid_decision

Overview:
- Downstream consumer of the per-side ultrasonic echo-width counters; takes the left and right echo times in clk cycles.
- Samples both times at a fixed interval, applies threshold hysteresis and N-sample confirmation per side, and sets per-side obstacle flags.
- Runs a timed manoeuvre state machine that issues the drive command to the motor stage.

Parameters:
- SAMPLE_CYCLES, 3000000, sample interval in clk cycles (60 ms at 50 MHz).
- NEAR_TH, 58000, echo time below which a sample is "near" (about 20 cm at 2900 cycles/cm).
- CLEAR_TH, 87000, echo time at or above which a sample is "clear" (about 30 cm). Must satisfy CLEAR_TH > NEAR_TH.
- CONFIRM, 3, consecutive near samples needed to set a flag (1..15).
- BACK_CYCLES, 15000000, duration of the reverse manoeuvre.
- TURN_CYCLES, 25000000, duration of a turn manoeuvre.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- left_time  in  20  left echo width in clk cycles; stable between updates; 0 = no measurement.
- right_time  in  20  right echo width in clk cycles; same rules as left_time.
- cmd  out  3  drive command: 000 STOP, 001 FWD, 010 BACK, 011 LEFT, 100 RIGHT.
- obstacle_l  out  1  confirmed left obstacle.
- obstacle_r  out  1  confirmed right obstacle.
- busy  out  1  high while a manoeuvre is in progress.

Behaviour:
- Reset values: cmd=000, obstacle_l=0, obstacle_r=0, busy=0. Sample counter, confirm counters and manoeuvre timer are all 0. State=START. Reset asserted mid-manoeuvre aborts to these values immediately.
- Sample tick:
  - The sample counter runs 0..SAMPLE_CYCLES-1 and wraps to 0.
  - tick is high for the one cycle in which the counter equals SAMPLE_CYCLES-1.
- Per-side classification on tick, using unsigned 20-bit compares. Each side is handled independently and identically:
  - time==0: ignored. Confirm counter and flag unchanged.
  - 0<time<NEAR_TH (near): confirm counter increments, saturating at CONFIRM. The flag is set on the tick where the counter reaches CONFIRM.
  - time>=CLEAR_TH (clear): confirm counter=0, flag cleared on that tick.
  - NEAR_TH<=time<CLEAR_TH (hysteresis band): confirm counter=0, flag unchanged.
- Flags update on the same edge as the tick and are visible the following cycle.
- FSM. State, cmd and busy are all registered and updated on the same edge; cmd is a decode of the next state.
  - START: cmd=STOP. On the first tick -> FWD.
  - FWD: cmd=FWD, busy=0. Flags are evaluated every cycle:
    - obstacle_l only -> TURN_R.
    - obstacle_r only -> TURN_L.
    - both -> BACKOFF.
    - none -> stay.
  - BACKOFF: cmd=BACK, busy=1. Lasts BACK_CYCLES cycles, then:
    - -> TURN_L if left_time>right_time.
    - otherwise -> TURN_R (a tie goes right).
    - A zero time counts as 0 in this comparison.
  - TURN_L / TURN_R: cmd=LEFT / RIGHT, busy=1. Lasts TURN_CYCLES cycles, then -> FWD.
- Manoeuvre timing:
  - The timer loads 0 on state entry and exits when it reaches duration-1, so the state is held for exactly the duration in cycles.
  - Flags continue to update during manoeuvres but do not affect the FSM until it is back in FWD.
  - If a flag is still set on return to FWD, the next manoeuvre starts on the following cycle.
- The sample counter runs freely; it is never reset by FSM transitions.

Optional Feature:
- Macro: AVOID_BACKOFF_EN.
- Defined: behaviour exactly as above.
- Undefined:
  - The BACKOFF state does not exist.
  - In FWD, both flags set -> TURN_L if left_time>right_time, else TURN_R, using the time values in that cycle.
  - cmd never drives BACK (010).
  - BACK_CYCLES is unused.

Test Plan (bench params: SAMPLE_CYCLES=100, NEAR_TH=1000, CLEAR_TH=1500, CONFIRM=3, BACK_CYCLES=300, TURN_CYCLES=500):
- Reset, both times=5000: cmd=000 until the first tick (cycle 99). Then cmd=001, flags stay 0, busy=0.
- right_time=800 for 3 ticks: obstacle_r=1 after the 3rd tick, not after the 2nd. Next cycle cmd=011 and busy=1 for exactly 500 cycles, then cmd=001.
- left_time=800, right_time=800 (AVOID_BACKOFF_EN defined): cmd=010 for 300 cycles, then 100 (tie -> right) for 500 cycles. With the macro undefined: cmd goes straight to 100 and never shows 010.
- Flag set, then right_time=1200 (hysteresis band): obstacle_r stays 1. Then right_time=1600: it clears on that tick. Alternating 800/0/800/0/800 also sets the flag, because zero samples are ignored.
- Near, near, band, near, near: the band sample resets the confirm count and no flag is set. A third consecutive near then sets it.
- Assert rst_n low mid-TURN_L for 1 cycle: cmd=000, flags=0, busy=0 asynchronously. On release the block restarts in START.
